// File: rtl/spifi_mem_arb.sv
// spifi_mem_arb
// Two-master AHB-Lite arbiter in front of the SPIFI memory port.
// Master 0 is the cache line fill path and master 1 is the prefetch path.
//
// Ports
//   i_hclk, i_hnreset               clock and synchronous active-low reset
//   i_mN_req / o_mN_gnt             bus request / grant, N = 0,1
//   i_mN_h*                         master N address-phase and write-data signals
//   o_mN_hresp                      response, steered to the master owning the data phase
//   o_m_hready, o_m_hrdata          shared ready / read data back to both masters
//   o_s_h*                          slave-side address phase, hwdata and hready_i
//   i_s_hrdata, i_s_hready_o,
//   i_s_hresp                       slave responses
module spifi_mem_arb #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        i_hclk,
  input  logic        i_hnreset,

  input  logic        i_m0_req,
  output logic        o_m0_gnt,
  input  logic [31:0] i_m0_haddr,
  input  logic        i_m0_hwrite,
  input  logic [2:0]  i_m0_hsize,
  input  logic [2:0]  i_m0_hburst,
  input  logic [3:0]  i_m0_hprot,
  input  logic [1:0]  i_m0_htrans,
  input  logic        i_m0_hmastlock,
  input  logic [31:0] i_m0_hwdata,
  output logic        o_m0_hresp,

  input  logic        i_m1_req,
  output logic        o_m1_gnt,
  input  logic [31:0] i_m1_haddr,
  input  logic        i_m1_hwrite,
  input  logic [2:0]  i_m1_hsize,
  input  logic [2:0]  i_m1_hburst,
  input  logic [3:0]  i_m1_hprot,
  input  logic [1:0]  i_m1_htrans,
  input  logic        i_m1_hmastlock,
  input  logic [31:0] i_m1_hwdata,
  output logic        o_m1_hresp,

  output logic        o_m_hready,
  output logic [31:0] o_m_hrdata,

  output logic        o_s_hsel,
  output logic [31:0] o_s_haddr,
  output logic        o_s_hwrite,
  output logic [2:0]  o_s_hsize,
  output logic [2:0]  o_s_hburst,
  output logic [3:0]  o_s_hprot,
  output logic [1:0]  o_s_htrans,
  output logic        o_s_hmastlock,
  output logic [31:0] o_s_hwdata,
  output logic        o_s_hready_i,

  input  logic [31:0] i_s_hrdata,
  input  logic        i_s_hready_o,
  input  logic        i_s_hresp
);

  // Owner encoding, shared by the address owner (AO) and data owner (DO).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int unsigned CW = $clog2(HOLD_MAX) + 1;
  localparam logic [CW:0] HOLD_LIM = (CW+1)'(HOLD_MAX);

  logic [1:0]    ao_q, ao_d;
  logic [1:0]    do_q, do_d;
  logic          last_q, last_d;   // 1: master 1 was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dph_q, dph_d;     // data phase in flight is a real transfer

  logic [1:0]    own_trans;
  logic [2:0]    own_burst;
  logic          own_lock;
  logic          can_release;
  logic          beat_now;
  logic [CW:0]   beats_incl;
  logic          hold_done;

  // Address-phase mux from the current address owner.
  always_comb begin
    o_s_haddr     = '0;
    o_s_hwrite    = 1'b0;
    o_s_hsize     = '0;
    o_s_hburst    = '0;
    o_s_hprot     = '0;
    o_s_htrans    = HTRANS_IDLE;
    o_s_hmastlock = 1'b0;
    case (ao_q)
      OWN0: begin
        o_s_haddr     = i_m0_haddr;
        o_s_hwrite    = i_m0_hwrite;
        o_s_hsize     = i_m0_hsize;
        o_s_hburst    = i_m0_hburst;
        o_s_hprot     = i_m0_hprot;
        o_s_htrans    = i_m0_htrans;
        o_s_hmastlock = i_m0_hmastlock;
      end
      OWN1: begin
        o_s_haddr     = i_m1_haddr;
        o_s_hwrite    = i_m1_hwrite;
        o_s_hsize     = i_m1_hsize;
        o_s_hburst    = i_m1_hburst;
        o_s_hprot     = i_m1_hprot;
        o_s_htrans    = i_m1_htrans;
        o_s_hmastlock = i_m1_hmastlock;
      end
      default: ;
    endcase
  end

  assign own_trans = o_s_htrans;
  assign own_burst = o_s_hburst;
  assign own_lock  = o_s_hmastlock;
  assign o_s_hsel  = (ao_q != IDLE);

  // Handover is only safe on a burst boundary of an unlocked owner.
  assign can_release = (ao_q == IDLE) ||
                       (!own_lock &&
                        ((own_trans == HTRANS_IDLE) ||
                         ((own_trans == HTRANS_NONSEQ) && (own_burst == HBURST_SINGLE))));

  // The beat completing this cycle counts toward the hold limit so the
  // grant moves right after the HOLD_MAX-th beat rather than one later.
  assign beat_now   = i_s_hready_o && dph_q && (do_q == ao_q) && (ao_q != IDLE);
  assign beats_incl = {1'b0, cnt_q} + (CW+1)'(beat_now);
  assign hold_done  = (beats_incl >= HOLD_LIM);

  always_comb begin
    ao_d   = ao_q;
    last_d = last_q;
    // i_s_hresp blocks the second (ready) cycle of an ERROR response.
    if (i_s_hready_o && !i_s_hresp && can_release) begin
      case (ao_q)
        OWN0: begin
          if (!i_m0_req)                   ao_d = i_m1_req ? OWN1 : IDLE;
          else if (i_m1_req && hold_done)  ao_d = OWN1;
        end
        OWN1: begin
          if (!i_m1_req)                   ao_d = i_m0_req ? OWN0 : IDLE;
          else if (i_m0_req && hold_done)  ao_d = OWN0;
        end
        default: begin
          if (i_m0_req && i_m1_req)        ao_d = last_q ? OWN0 : OWN1;
          else if (i_m0_req)               ao_d = OWN0;
          else if (i_m1_req)               ao_d = OWN1;
        end
      endcase
    end
    if ((ao_d != ao_q) && (ao_d != IDLE)) last_d = (ao_d == OWN1);
  end

  always_comb begin
    do_d  = do_q;
    dph_d = dph_q;
    if (i_s_hready_o) begin
      do_d  = ao_q;
      dph_d = own_trans[1];
    end
    cnt_d = cnt_q;
    if (ao_d != ao_q)              cnt_d = '0;
    else if (beat_now && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hnreset) begin
      ao_q   <= IDLE;
      do_q   <= IDLE;
      last_q <= 1'b1;
      cnt_q  <= '0;
      dph_q  <= 1'b0;
    end else begin
      ao_q   <= ao_d;
      do_q   <= do_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      dph_q  <= dph_d;
    end
  end

  assign o_m0_gnt = (ao_q == OWN0);
  assign o_m1_gnt = (ao_q == OWN1);

  always_comb begin
    o_s_hwdata = '0;
    case (do_q)
      OWN0:    o_s_hwdata = i_m0_hwdata;
      OWN1:    o_s_hwdata = i_m1_hwdata;
      default: ;
    endcase
  end

  assign o_m0_hresp   = (do_q == OWN0) ? i_s_hresp : 1'b0;
  assign o_m1_hresp   = (do_q == OWN1) ? i_s_hresp : 1'b0;
  assign o_m_hready   = i_s_hready_o;
  assign o_m_hrdata   = i_s_hrdata;
  assign o_s_hready_i = i_s_hready_o;

endmodule

// File: tb/tb_spifi_mem_arb.sv
module tb_spifi_mem_arb;

  logic        clk = 1'b0;
  logic        nrst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic        m0_hwrite, m1_hwrite, m0_lock, m1_lock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hresp, m1_hresp, m_hready;
  logic [31:0] m_hrdata;
  logic        s_hsel, s_hwrite, s_hmastlock, s_hready_i;
  logic [31:0] s_haddr, s_hwdata;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [31:0] s_hrdata;
  logic        s_hready, s_hresp;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed { logic g0; logic g1; } gexp_t;
  gexp_t gq[$];
  gexp_t e;

  always #5 clk = ~clk;

  spifi_mem_arb #(.HOLD_MAX(4)) dut (
    .i_hclk(clk), .i_hnreset(nrst),
    .i_m0_req(m0_req), .o_m0_gnt(m0_gnt), .i_m0_haddr(m0_haddr), .i_m0_hwrite(m0_hwrite),
    .i_m0_hsize(m0_hsize), .i_m0_hburst(m0_hburst), .i_m0_hprot(m0_hprot), .i_m0_htrans(m0_htrans),
    .i_m0_hmastlock(m0_lock), .i_m0_hwdata(m0_hwdata), .o_m0_hresp(m0_hresp),
    .i_m1_req(m1_req), .o_m1_gnt(m1_gnt), .i_m1_haddr(m1_haddr), .i_m1_hwrite(m1_hwrite),
    .i_m1_hsize(m1_hsize), .i_m1_hburst(m1_hburst), .i_m1_hprot(m1_hprot), .i_m1_htrans(m1_htrans),
    .i_m1_hmastlock(m1_lock), .i_m1_hwdata(m1_hwdata), .o_m1_hresp(m1_hresp),
    .o_m_hready(m_hready), .o_m_hrdata(m_hrdata),
    .o_s_hsel(s_hsel), .o_s_haddr(s_haddr), .o_s_hwrite(s_hwrite), .o_s_hsize(s_hsize),
    .o_s_hburst(s_hburst), .o_s_hprot(s_hprot), .o_s_htrans(s_htrans), .o_s_hmastlock(s_hmastlock),
    .o_s_hwdata(s_hwdata), .o_s_hready_i(s_hready_i),
    .i_s_hrdata(s_hrdata), .i_s_hready_o(s_hready), .i_s_hresp(s_hresp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_haddr = 32'h1000_0000; m1_haddr = 32'h2000_0000;
    m0_hwdata = 32'hD0D0_0000; m1_hwdata = 32'hD1D1_0000;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    m0_hsize = 3'b010; m1_hsize = 3'b010; m0_hburst = 3'b000; m1_hburst = 3'b000;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011; m0_htrans = 2'b00; m1_htrans = 2'b00;
    s_hrdata = 32'h0BAD_F00D; s_hready = 1'b1; s_hresp = 1'b1;
    tick(); tick();
    n_vec++;
    if ({m0_gnt, m1_gnt, s_hsel, s_htrans, m0_hresp, m1_hresp} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state got gnt=%b%b hsel=%b htrans=%b hresp=%b%b required all 0",
               m0_gnt, m1_gnt, s_hsel, s_htrans, m0_hresp, m1_hresp);
    end
    n_vec++;
    if (s_haddr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_haddr got %h required 0", s_haddr);
    end
    s_hready = 1'b0; s_hrdata = 32'h1234_5678; #1;
    n_vec++;
    if ({m_hready, s_hready_i, m_hrdata} !== {1'b0, 1'b0, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL passthrough got hready=%b hready_i=%b hrdata=%h required 0 0 12345678",
               m_hready, s_hready_i, m_hrdata);
    end
    s_hready = 1'b1; s_hresp = 1'b0;
  endtask

  task automatic test_tie();
    nrst = 1'b1;
    gq.push_back('{g0: 1'b1, g1: 1'b0});
    tick();
    e = gq.pop_front();
    n_vec++;
    if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
      n_err++;
      $display("FAIL tie_gnt got %b%b required %b%b", m0_gnt, m1_gnt, e.g0, e.g1);
    end
    n_vec++;
    if ({s_hsel, s_haddr} !== {1'b1, m0_haddr}) begin
      n_err++;
      $display("FAIL tie_route got hsel=%b haddr=%h required 1 %h", s_hsel, s_haddr, m0_haddr);
    end
    m1_req = 1'b0;
  endtask

  task automatic test_burst();
    for (int k = 0; k <= 8; k++) begin
      m0_htrans = (k == 0) ? 2'b10 : ((k == 8) ? 2'b00 : 2'b11);
      m0_hburst = 3'b101;
      m0_haddr  = 32'h1000_0000 + 32'(k * 4);
      m0_hwdata = 32'hA000_0000 + 32'(k);
      m1_req    = (k >= 3);
      gq.push_back((k == 8) ? '{g0: 1'b0, g1: 1'b1} : '{g0: 1'b1, g1: 1'b0});
      tick();
      e = gq.pop_front();
      n_vec++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        n_err++;
        $display("FAIL burst_gnt k=%0d got %b%b required %b%b", k, m0_gnt, m1_gnt, e.g0, e.g1);
      end
      if (k < 8) begin
        n_vec++;
        if (s_hwdata !== m0_hwdata) begin
          n_err++;
          $display("FAIL burst_hwdata k=%0d got %h required %h", k, s_hwdata, m0_hwdata);
        end
      end
    end
    m0_hburst = 3'b000;
  endtask

  task automatic test_hold();
    m0_htrans = 2'b00;
    for (int j = 0; j < 10; j++) begin
      m1_htrans = 2'b10; m1_hburst = 3'b000;
      m1_haddr  = 32'h2000_0000 + 32'(j * 4);
      m0_req    = (j >= 1);
      s_hrdata  = 32'hC0DE_0000 + 32'(j);
      #1;
      n_vec++;
      if (m_hrdata !== 32'hC0DE_0000 + 32'(j)) begin
        n_err++;
        $display("FAIL hold_hrdata j=%0d got %h required %h", j, m_hrdata, 32'hC0DE_0000 + 32'(j));
      end
      gq.push_back((j >= 4) ? '{g0: 1'b1, g1: 1'b0} : '{g0: 1'b0, g1: 1'b1});
      tick();
      e = gq.pop_front();
      n_vec++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        n_err++;
        $display("FAIL hold_gnt j=%0d got %b%b required %b%b", j, m0_gnt, m1_gnt, e.g0, e.g1);
      end
    end
  endtask

  task automatic test_lock();
    for (int i = -1; i <= 20; i++) begin
      m0_req    = (i >= 0);
      m0_htrans = 2'b00;
      m1_req    = 1'b1;
      m1_htrans = (i < 0) ? 2'b00 : 2'b10;
      m1_hburst = 3'b000;
      m1_lock   = (i >= 0) && (i < 20);
      gq.push_back((i == 20) ? '{g0: 1'b1, g1: 1'b0} : '{g0: 1'b0, g1: 1'b1});
      tick();
      e = gq.pop_front();
      n_vec++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        n_err++;
        $display("FAIL lock_gnt i=%0d got %b%b required %b%b", i, m0_gnt, m1_gnt, e.g0, e.g1);
      end
    end
    m1_lock = 1'b0;
  endtask

  task automatic test_wait_states();
    for (int w = 0; w <= 4; w++) begin
      m0_req    = (w == 0);
      m0_htrans = (w == 0) ? 2'b10 : 2'b00;
      m0_hwrite = (w == 0);
      m1_req    = (w != 0);
      m1_htrans = 2'b00;
      s_hready  = (w == 0) || (w == 4);
      if (w == 0) m0_hwdata = 32'h5EED_0000;
      m1_hwdata = 32'hBEEF_0000 + 32'(w);
      #1;
      if (w >= 1) begin
        n_vec++;
        if ({m_hready, s_hwdata} !== {(w == 4), 32'h5EED_0000}) begin
          n_err++;
          $display("FAIL wait_hwdata w=%0d got hready=%b hwdata=%h required %b 5eed0000",
                   w, m_hready, s_hwdata, (w == 4));
        end
      end
      gq.push_back((w == 4) ? '{g0: 1'b0, g1: 1'b1} : '{g0: 1'b1, g1: 1'b0});
      tick();
      e = gq.pop_front();
      n_vec++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        n_err++;
        $display("FAIL wait_gnt w=%0d got %b%b required %b%b", w, m0_gnt, m1_gnt, e.g0, e.g1);
      end
    end
    m0_hwrite = 1'b0; s_hready = 1'b1;
  endtask

  task automatic test_error();
    logic [1:0] rexp;
    for (int c = 0; c <= 4; c++) begin
      case (c)
        0: begin m1_req = 1'b0; m1_htrans = 2'b00; m0_req = 1'b1; m0_htrans = 2'b00; end
        1: begin m0_htrans = 2'b10; m0_req = 1'b0; m1_req = 1'b1; m1_htrans = 2'b10; end
        default: begin m0_req = 1'b1; m0_htrans = 2'b00; m1_req = 1'b0; m1_htrans = 2'b10; end
      endcase
      s_hresp  = (c == 2) || (c == 3);
      s_hready = (c != 2);
      #1;
      if (c >= 2) begin
        rexp = (c == 4) ? 2'b00 : 2'b10;
        n_vec++;
        if ({m0_hresp, m1_hresp} !== rexp) begin
          n_err++;
          $display("FAIL error_hresp c=%0d got %b%b required %b", c, m0_hresp, m1_hresp, rexp);
        end
      end
      gq.push_back(((c == 0) || (c == 4)) ? '{g0: 1'b1, g1: 1'b0} : '{g0: 1'b0, g1: 1'b1});
      tick();
      e = gq.pop_front();
      n_vec++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        n_err++;
        $display("FAIL error_gnt c=%0d got %b%b required %b%b", c, m0_gnt, m1_gnt, e.g0, e.g1);
      end
    end
    s_hresp = 1'b0; s_hready = 1'b1;
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_htrans = 2'b10; m0_hburst = 3'b011; m1_req = 1'b1;
    nrst = 1'b0;
    gq.push_back('{g0: 1'b0, g1: 1'b0});
    tick();
    e = gq.pop_front();
    n_vec++;
    if ({m0_gnt, m1_gnt, s_hsel, s_htrans} !== {e.g0, e.g1, 3'b000}) begin
      n_err++;
      $display("FAIL rstmid_gnt got gnt=%b%b hsel=%b htrans=%b required %b%b 0 00",
               m0_gnt, m1_gnt, s_hsel, s_htrans, e.g0, e.g1);
    end
    nrst = 1'b1; m0_req = 1'b0; m0_htrans = 2'b00; m0_hburst = 3'b000;
    gq.push_back('{g0: 1'b0, g1: 1'b1});
    tick();
    e = gq.pop_front();
    n_vec++;
    if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
      n_err++;
      $display("FAIL rstmid_regrant got %b%b required %b%b", m0_gnt, m1_gnt, e.g0, e.g1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_burst();
    test_hold();
    test_lock();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spifi_mem_arb.md
SPIFI_MEM_ARB -- requirements
Module: spifi_mem_arb

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: maximum data-phase beats a grant is kept while the other master is requesting; it only takes effect where REQ-014 permits a handover.
REQ-002 SHALL have port i_hclk, in, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_hnreset, in, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports i_mN_req, in, 1, N=0,1: bus request (m0 = cache line fill, m1 = prefetch).
REQ-005 SHALL have ports o_mN_gnt, out, 1: bus grant to master N.
REQ-006 SHALL have ports i_mN_haddr in 32, i_mN_hwrite in 1, i_mN_hsize in 3, i_mN_hburst in 3, i_mN_hprot in 4, i_mN_htrans in 2, i_mN_hmastlock in 1, i_mN_hwdata in 32: master N AHB-Lite address/data signals.
REQ-007 SHALL have ports o_mN_hresp, out, 1: response to master N.
REQ-008 SHALL have port o_m_hready, out, 1: shared HREADY to both masters.
REQ-009 SHALL have port o_m_hrdata, out, 32: shared read data to both masters.
REQ-010 SHALL have ports o_s_hsel out 1, o_s_haddr out 32, o_s_hwrite out 1, o_s_hsize out 3, o_s_hburst out 3, o_s_hprot out 4, o_s_htrans out 2, o_s_hmastlock out 1, o_s_hwdata out 32, o_s_hready_i out 1: SPIFI memory-port slave side.
REQ-011 SHALL have ports i_s_hrdata in 32, i_s_hready_o in 1, i_s_hresp in 1: SPIFI memory-port responses.

Function
REQ-012 SHALL keep address owner AO (NONE/M0/M1) as a state machine with states IDLE, OWN0, OWN1; o_mN_gnt = (AO==MN).
REQ-013 SHALL evaluate grant changes only in cycles with i_s_hready_o=1; a new AO is visible the following cycle.
REQ-014 SHALL release ownership only when the owner's htrans is IDLE or NONSEQ-start of no burst (not SEQ/BUSY) and hmastlock=0; a locked or mid-burst owner is never pre-empted.
REQ-015 SHALL re-arbitrate when the owner drops req, or when the other master requests and HOLD_MAX data beats have completed under the current grant and REQ-014 permits.
REQ-016 SHALL, on simultaneous requests from IDLE, grant the master not granted last (round-robin); last-granted register resets to M1 so M0 wins the first tie.
REQ-017 SHALL route owner's address-phase signals to o_s_*; with AO=NONE drive o_s_htrans=IDLE, o_s_hsel=0, others 0.
REQ-018 SHALL register data owner DO <= AO when i_s_hready_o=1; o_s_hwdata = DO master's hwdata.
REQ-019 SHALL drive o_mN_hresp = i_s_hresp only when DO==MN, else 0.
REQ-020 SHALL pass o_m_hready = i_s_hready_o and o_m_hrdata = i_s_hrdata combinationally; o_s_hready_i = i_s_hready_o.
REQ-021 SHALL count beats with a saturating counter (width clog2(HOLD_MAX)+1), cleared on grant change, incremented on each i_s_hready_o=1 cycle with DO==AO and a data phase active.
REQ-022 SHALL, on an ERROR response (two-cycle i_s_hresp), hold AO unchanged until the second cycle completes.
REQ-023 SHALL not grant a master whose req is low; a grant with req low during handover lasts at most one cycle with htrans IDLE driven.

Reset
REQ-024 SHALL, with i_hnreset=0 at a clock edge, set AO=NONE, DO=NONE, last-granted=M1, beat counter=0, o_mN_gnt=0, o_s_htrans=IDLE, o_s_hsel=0, o_mN_hresp=0.
REQ-025 SHALL, on reset mid-transfer, abandon the transfer without completing it; first grant possible the cycle after i_hnreset returns high.

Verification
REQ-026 Reset then m0_req=m1_req=1 same cycle -> o_m0_gnt=1 next cycle, o_m1_gnt=0.
REQ-027 m0 INCR8 burst in progress, m1_req rises at beat 3 -> m0 keeps grant until beat 8 completes, o_m1_gnt=1 the cycle after m0 htrans IDLE.
REQ-028 HOLD_MAX=4, m1 issues 10 single NONSEQ reads, m0 requests at beat 1 -> grant moves to m0 after 4th completed beat.
REQ-029 m1 owns with hmastlock=1, m0 requesting for 20 cycles -> no grant change until hmastlock=0.
REQ-030 Slave inserts 3 wait states (i_s_hready_o=0) during handover -> AO/gnt unchanged until hready=1; o_s_hwdata stays old owner's data.
REQ-031 ERROR response to m0 data phase with m1 address phase pending -> o_m0_hresp=1 two cycles, o_m1_hresp=0, no grant change during ERROR.
